// File: rtl/sprite_collision_mover.sv
// Player sprite mover: each stepped candidate position is probed pixel by pixel
// against the registered boundary mask before the move is committed.
module sprite_collision_mover #(
    parameter int START_X  = 40,
    parameter int START_Y  = 30,
    parameter int SPRITE_W = 3,
    parameter int SPRITE_H = 3,
    parameter int SCREEN_W = 96,
    parameter int SCREEN_H = 64
) (
    input  logic       clk50,
    input  logic       reset,
    input  logic       move_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       map_in,
    output logic [6:0] probe_x,
    output logic [6:0] probe_y,
    output logic [6:0] pos_x,
    output logic [6:0] pos_y,
    output logic       busy,
    output logic       moved,
    output logic       blocked
);

    typedef enum logic [1:0] {IDLE, PROBE, WAIT, DECIDE} state_t;

    localparam logic [2:0] DX_LAST = 3'(SPRITE_W - 1);
    localparam logic [2:0] DY_LAST = 3'(SPRITE_H - 1);

    state_t      state, state_nxt;
    logic [6:0]  cand_x, cand_y, cand_x_nxt, cand_y_nxt;
    logic [6:0]  pos_x_nxt, pos_y_nxt, probe_x_nxt, probe_y_nxt;
    logic [2:0]  dx, dy, dx_nxt, dy_nxt;
    logic        ok, ok_nxt;
    logic        busy_nxt, moved_nxt, blocked_nxt;

    // One extra sign bit so that stepping left/up from 0 yields -1 instead of wrapping.
    logic signed [7:0] step_x, step_y;
    logic              step_req, off_screen;

    always_comb begin
        step_x   = $signed({1'b0, pos_x});
        step_y   = $signed({1'b0, pos_y});
        step_req = 1'b1;
        if (btn_up)
            step_y = $signed({1'b0, pos_y}) - 8'sd1;
        else if (btn_down)
            step_y = $signed({1'b0, pos_y}) + 8'sd1;
        else if (btn_left)
            step_x = $signed({1'b0, pos_x}) - 8'sd1;
        else if (btn_right)
            step_x = $signed({1'b0, pos_x}) + 8'sd1;
        else
            step_req = 1'b0;
        off_screen = (int'(step_x) < 0) || (int'(step_y) < 0) ||
                     (int'(step_x) + SPRITE_W > SCREEN_W) ||
                     (int'(step_y) + SPRITE_H > SCREEN_H);
    end

    // NOTE: every register's next value is defaulted first so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        cand_x_nxt  = cand_x;
        cand_y_nxt  = cand_y;
        pos_x_nxt   = pos_x;
        pos_y_nxt   = pos_y;
        probe_x_nxt = probe_x;
        probe_y_nxt = probe_y;
        dx_nxt      = dx;
        dy_nxt      = dy;
        ok_nxt      = ok;
        busy_nxt    = busy;
        moved_nxt   = 1'b0;
        blocked_nxt = 1'b0;

        case (state)
            IDLE: begin
                probe_x_nxt = pos_x;
                probe_y_nxt = pos_y;
                if (move_tick && step_req) begin
                    if (off_screen) begin
                        blocked_nxt = 1'b1;
                    end else begin
                        cand_x_nxt  = step_x[6:0];
                        cand_y_nxt  = step_y[6:0];
                        probe_x_nxt = step_x[6:0];
                        probe_y_nxt = step_y[6:0];
                        dx_nxt      = 3'd0;
                        dy_nxt      = 3'd0;
                        ok_nxt      = 1'b1;
                        busy_nxt    = 1'b1;
                        state_nxt   = PROBE;
                    end
                end
            end
            PROBE: begin
                // map_in answers the previous cycle's probe, so the first cycle has nothing yet.
                if (dx != 3'd0 || dy != 3'd0)
                    ok_nxt = ok & map_in;
                if (dx == DX_LAST) begin
                    dx_nxt = 3'd0;
                    if (dy == DY_LAST)
                        state_nxt = WAIT;
                    else
                        dy_nxt = dy + 3'd1;
                end else begin
                    dx_nxt = dx + 3'd1;
                end
                probe_x_nxt = cand_x + 7'(dx_nxt);
                probe_y_nxt = cand_y + 7'(dy_nxt);
            end
            WAIT: begin
                // Commit here so the new position and pulse are visible during DECIDE.
                ok_nxt = ok & map_in;
                if (ok & map_in) begin
                    pos_x_nxt = cand_x;
                    pos_y_nxt = cand_y;
                    moved_nxt = 1'b1;
                end else begin
                    blocked_nxt = 1'b1;
                end
                state_nxt = DECIDE;
            end
            DECIDE: begin
                busy_nxt    = 1'b0;
                probe_x_nxt = pos_x;
                probe_y_nxt = pos_y;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk50) begin
        if (reset) begin
            state   <= IDLE;
            cand_x  <= 7'(START_X);
            cand_y  <= 7'(START_Y);
            pos_x   <= 7'(START_X);
            pos_y   <= 7'(START_Y);
            probe_x <= 7'(START_X);
            probe_y <= 7'(START_Y);
            dx      <= 3'd0;
            dy      <= 3'd0;
            ok      <= 1'b1;
            busy    <= 1'b0;
            moved   <= 1'b0;
            blocked <= 1'b0;
        end else begin
            state   <= state_nxt;
            cand_x  <= cand_x_nxt;
            cand_y  <= cand_y_nxt;
            pos_x   <= pos_x_nxt;
            pos_y   <= pos_y_nxt;
            probe_x <= probe_x_nxt;
            probe_y <= probe_y_nxt;
            dx      <= dx_nxt;
            dy      <= dy_nxt;
            ok      <= ok_nxt;
            busy    <= busy_nxt;
            moved   <= moved_nxt;
            blocked <= blocked_nxt;
        end
    end

endmodule
